manual_phase_ctrl: RTL and testbench
====================================

// Module: manual_phase_ctrl
// PURPOSE
//  Parametrised manual-mode lamp controller for NUM_LANES approaches. Operator switches select one
//  lane to be green; the block debounces them and inserts yellow and all-red clearance between greens.
//  Sits between the manual switch inputs and the lamp drivers.
// PARAMETERS
//  NUM_LANES        2  number of approaches, 2..16; LANE_W = $clog2(NUM_LANES) (localparam)
//  DEBOUNCE_CYCLES  4  consecutive stable cycles needed before a selection change is accepted, >=1
//  YELLOW_CYCLES    3  yellow dwell of the outgoing lane, >=1
//  ALLRED_CYCLES    2  all-red clearance before any green, >=1
//  CNT_W            8  timer width; every *_CYCLES value must be < 2**CNT_W
// PORTS
//  clk       in   1          system clock, rising edge
//  rst_n     in   1          asynchronous active-low reset
//  sw        in   NUM_LANES  raw manual switches, asynchronous; sw[i]=1 requests green for lane i
//  red       out  NUM_LANES  red lamp per lane
//  yel       out  NUM_LANES  yellow lamp per lane
//  grn       out  NUM_LANES  green lamp per lane
//  lane_idx  out  LANE_W     lane that is currently green or yellow, or the last such lane
//  phase     out  2          0=OFF 1=GREEN 2=YELLOW 3=ALLRED
//  busy      out  1          1 in YELLOW or ALLRED
// BEHAVIOUR
//  - Reset (async assert, sync release): phase=OFF; red/yel/grn=0; lane_idx=0; busy=0. Sync flops,
//    debounce counter, target and timer are cleared. Reset mid-sequence goes directly to OFF.
//  - Input path: each sw bit passes through a 2-flop synchroniser. A priority encoder on the synced
//    value gives raw_sel. The lowest set index wins, so sw[0] beats sw[1]. raw_valid = |synced.
//  - Debounce: {raw_valid,raw_sel} must equal its previous-cycle value for DEBOUNCE_CYCLES
//    consecutive cycles, then it loads {tgt_valid,tgt}. Any change restarts the count.
//    A pulse on sw shorter than DEBOUNCE_CYCLES+1 cycles never reaches tgt.
//  - FSM, one transition per clock. The timer loads N-1 on entry and the phase lasts exactly N cycles:
//     OFF:    if tgt_valid -> ALLRED (timer=ALLRED_CYCLES)
//     ALLRED: at timer expiry, sample tgt: if tgt_valid -> GREEN with lane_idx=tgt; else -> OFF
//     GREEN:  if !tgt_valid or tgt!=lane_idx -> YELLOW (timer=YELLOW_CYCLES); else hold
//     YELLOW: at expiry -> ALLRED. Target changes during YELLOW or ALLRED do not abort the
//             sequence, including a return to the same lane; only the value at ALLRED expiry counts.
//  - Lamps are registered and aligned with phase, so the lamps change in the same cycle as phase:
//     OFF: all zero. ALLRED: red=all ones. GREEN: grn[lane_idx]=1, red=all others.
//     YELLOW: yel[lane_idx]=1, red=all others.
//  - Invariants: at most one bit set across grn|yel; outside OFF, each lane has exactly one lamp on.
//    GREEN is never entered except from ALLRED.
//  - Latency: the first cycle of a steady sw change is cycle 0. tgt updates at cycle 2+DEBOUNCE_CYCLES,
//    and the FSM reacts on the following cycle.
// TESTING
//  1 rst_n=0 in any phase -> lamps=0, phase=0, busy=0 immediately; no activity after release with sw=0
//  2 defaults, sw=01 held -> ALLRED (red=11) for 2 cycles, then grn=01 red=10 phase=1 lane_idx=0, stable
//  3 from lane-0 GREEN, sw=10 -> yel=01 red=10 for 3 cycles, red=11 for 2 cycles, then grn=10 red=01
//  4 sw=11 from OFF -> lane 0 green; then sw=10 -> handover to lane 1 as in scenario 3
//  5 in GREEN lane 0, sw=10 for 3 cycles then back to 01 -> no phase change; 6-cycle pulse does change
//  6 in GREEN, sw=00 -> yellow 3 cycles, all-red 2 cycles, OFF all zero. sw=01 during YELLOW
//    -> full sequence still runs, then lane-0 green.

Source files
------------

// File: rtl/manual_phase_ctrl.sv
// Manual-mode lamp controller: synchronised, debounced lane selection driving a
// GREEN -> YELLOW -> ALLRED -> GREEN handover with registered lamp outputs.
//
// state  | meaning
// OFF    | no lane requested, all lamps dark
// GREEN  | lane_idx has right of way
// YELLOW | outgoing lane_idx clearing
// ALLRED | every lane red before the next green (or before going dark)
module manual_phase_ctrl #(
    parameter int NUM_LANES       = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int YELLOW_CYCLES   = 3,
    parameter int ALLRED_CYCLES   = 2,
    parameter int CNT_W           = 8,
    localparam int LANE_W         = $clog2(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] sw,
    output logic [NUM_LANES-1:0] red,
    output logic [NUM_LANES-1:0] yel,
    output logic [NUM_LANES-1:0] grn,
    output logic [LANE_W-1:0]    lane_idx,
    output logic [1:0]           phase,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_ALLRED = 2'd3
    } state_t;

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [NUM_LANES-1:0] r_sync1;
    logic [NUM_LANES-1:0] r_sync2;
    logic [LANE_W-1:0]    w_raw_sel;
    logic                 w_raw_valid;
    logic [LANE_W:0]      w_raw;
    logic [LANE_W:0]      r_prev;
    logic [CNT_W-1:0]     r_db_cnt;
    logic                 r_tgt_valid;
    logic [LANE_W-1:0]    r_tgt;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_timer;
    logic [CNT_W-1:0]     w_timer_nxt;
    logic [LANE_W-1:0]    r_lane;
    logic [LANE_W-1:0]    w_lane_nxt;
    logic [NUM_LANES-1:0] r_red;
    logic [NUM_LANES-1:0] r_yel;
    logic [NUM_LANES-1:0] r_grn;
    logic [NUM_LANES-1:0] w_red_nxt;
    logic [NUM_LANES-1:0] w_yel_nxt;
    logic [NUM_LANES-1:0] w_grn_nxt;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // Scan downward so the lowest set switch wins.
    always_comb begin
        w_raw_sel = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (r_sync2[i]) w_raw_sel = LANE_W'(i);
        end
    end
    assign w_raw_valid = |r_sync2;
    assign w_raw       = {w_raw_valid, w_raw_sel};

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_prev      <= '0;
            r_db_cnt    <= '0;
            r_tgt_valid <= 1'b0;
            r_tgt       <= '0;
        end else begin
            r_prev <= w_raw;
            if (w_raw != r_prev) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_tgt_valid <= w_raw[LANE_W];
                r_tgt       <= w_raw[LANE_W-1:0];
            end else begin
                r_db_cnt <= r_db_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_lane_nxt  = r_lane;
        case (r_state)
            S_OFF: begin
                if (r_tgt_valid) begin
                    w_state_nxt = S_ALLRED;
                    w_timer_nxt = CNT_W'(ALLRED_CYCLES - 1);
                end
            end
            S_ALLRED: begin
                if (r_timer == '0) begin
                    if (r_tgt_valid) begin
                        w_state_nxt = S_GREEN;
                        w_lane_nxt  = r_tgt;
                    end else begin
                        w_state_nxt = S_OFF;
                    end
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            S_GREEN: begin
                if (!r_tgt_valid || (r_tgt != r_lane)) begin
                    w_state_nxt = S_YELLOW;
                    w_timer_nxt = CNT_W'(YELLOW_CYCLES - 1);
                end
            end
            S_YELLOW: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_ALLRED;
                    w_timer_nxt = CNT_W'(ALLRED_CYCLES - 1);
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    // Lamps are decoded from the next state so they register in step with phase.
    always_comb begin
        w_red_nxt = '0;
        w_yel_nxt = '0;
        w_grn_nxt = '0;
        case (w_state_nxt)
            S_ALLRED: w_red_nxt = '1;
            S_GREEN: begin
                w_red_nxt             = '1;
                w_red_nxt[w_lane_nxt] = 1'b0;
                w_grn_nxt[w_lane_nxt] = 1'b1;
            end
            S_YELLOW: begin
                w_red_nxt             = '1;
                w_red_nxt[w_lane_nxt] = 1'b0;
                w_yel_nxt[w_lane_nxt] = 1'b1;
            end
            default: begin
                w_red_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_OFF;
            r_timer <= '0;
            r_lane  <= '0;
            r_red   <= '0;
            r_yel   <= '0;
            r_grn   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_lane  <= w_lane_nxt;
            r_red   <= w_red_nxt;
            r_yel   <= w_yel_nxt;
            r_grn   <= w_grn_nxt;
        end
    end

    assign red      = r_red;
    assign yel      = r_yel;
    assign grn      = r_grn;
    assign lane_idx = r_lane;
    assign phase    = r_state;
    assign busy     = (r_state == S_YELLOW) || (r_state == S_ALLRED);

endmodule

// File: tb/tb_manual_phase_ctrl.sv
// Directed bench for manual_phase_ctrl with default parameters (debounce 4, yellow 3, all-red 2).
module tb_manual_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sw;
    logic [1:0] red;
    logic [1:0] yel;
    logic [1:0] grn;
    logic [0:0] lane_idx;
    logic [1:0] phase;
    logic       busy;

    int checks = 0;
    int errors = 0;

    manual_phase_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .red      (red),
        .yel      (yel),
        .grn      (grn),
        .lane_idx (lane_idx),
        .phase    (phase),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_ph, input logic [1:0] e_red,
                           input logic [1:0] e_yel, input logic [1:0] e_grn, input logic e_busy);
        chk({tag, "/phase"}, {6'd0, phase}, {6'd0, e_ph});
        chk({tag, "/red"},   {6'd0, red},   {6'd0, e_red});
        chk({tag, "/yel"},   {6'd0, yel},   {6'd0, e_yel});
        chk({tag, "/grn"},   {6'd0, grn},   {6'd0, e_grn});
        chk({tag, "/busy"},  {7'd0, busy},  {7'd0, e_busy});
    endtask

    task automatic chk_lane(input string tag, input logic e_lane);
        chk({tag, "/lane"}, {7'd0, lane_idx}, {7'd0, e_lane});
    endtask

    initial begin
        rst_n = 1'b1;
        sw    = 2'b00;
        #2 rst_n = 1'b0;
        #30;
        chk_all("reset", 2'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        chk_lane("reset", 1'b0);
        @(negedge clk) rst_n = 1'b1;
        step(6);
        chk_all("idle", 2'd0, 2'b00, 2'b00, 2'b00, 1'b0);

        // lane 0 requested from OFF
        sw = 2'b01;
        step(7);
        chk_all("s2_pre", 2'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(1);
        chk_all("s2_ar0", 2'd3, 2'b11, 2'b00, 2'b00, 1'b1);
        step(1);
        chk_all("s2_ar1", 2'd3, 2'b11, 2'b00, 2'b00, 1'b1);
        step(1);
        chk_all("s2_grn", 2'd1, 2'b10, 2'b00, 2'b01, 1'b0);
        chk_lane("s2_grn", 1'b0);
        step(5);
        chk_all("s2_hold", 2'd1, 2'b10, 2'b00, 2'b01, 1'b0);

        // handover lane 0 -> lane 1
        sw = 2'b10;
        step(7);
        chk_all("s3_pre", 2'd1, 2'b10, 2'b00, 2'b01, 1'b0);
        step(1);
        chk_all("s3_y0", 2'd2, 2'b10, 2'b01, 2'b00, 1'b1);
        chk_lane("s3_y0", 1'b0);
        step(2);
        chk_all("s3_y2", 2'd2, 2'b10, 2'b01, 2'b00, 1'b1);
        step(1);
        chk_all("s3_ar0", 2'd3, 2'b11, 2'b00, 2'b00, 1'b1);
        step(1);
        chk_all("s3_ar1", 2'd3, 2'b11, 2'b00, 2'b00, 1'b1);
        step(1);
        chk_all("s3_grn", 2'd1, 2'b01, 2'b00, 2'b10, 1'b0);
        chk_lane("s3_grn", 1'b1);

        // release all switches, then reset in the middle of yellow
        sw = 2'b00;
        step(8);
        chk_all("s1_yel", 2'd2, 2'b01, 2'b10, 2'b00, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk_all("s1_rst", 2'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        chk_lane("s1_rst", 1'b0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(5);
            chk_all("s1_quiet", 2'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        end

        // both switches on: lane 0 has priority
        sw = 2'b11;
        step(7);
        chk_all("s4_pre", 2'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(1);
        chk_all("s4_ar", 2'd3, 2'b11, 2'b00, 2'b00, 1'b1);
        step(2);
        chk_all("s4_grn", 2'd1, 2'b10, 2'b00, 2'b01, 1'b0);
        chk_lane("s4_grn", 1'b0);
        sw = 2'b10;
        step(8);
        chk_all("s4_y", 2'd2, 2'b10, 2'b01, 2'b00, 1'b1);
        step(5);
        chk_all("s4_grn1", 2'd1, 2'b01, 2'b00, 2'b10, 1'b0);
        chk_lane("s4_grn1", 1'b1);
        sw = 2'b01;
        step(8);
        chk_all("s4_yb", 2'd2, 2'b01, 2'b10, 2'b00, 1'b1);
        step(5);
        chk_all("s4_grn0", 2'd1, 2'b10, 2'b00, 2'b01, 1'b0);
        chk_lane("s4_grn0", 1'b0);

        // 3-cycle glitch toward lane 1 is filtered
        sw = 2'b10;
        step(3);
        sw = 2'b01;
        for (int i = 0; i < 15; i++) begin
            step(1);
            chk("s5_hold", {6'd0, phase}, 8'd1);
        end
        chk_all("s5_hold_end", 2'd1, 2'b10, 2'b00, 2'b01, 1'b0);

        // 6-cycle pulse passes; the return to lane 0 during handover does not abort it
        sw = 2'b10;
        step(6);
        sw = 2'b01;
        step(1);
        chk_all("s5_pre", 2'd1, 2'b10, 2'b00, 2'b01, 1'b0);
        step(1);
        chk_all("s5_y", 2'd2, 2'b10, 2'b01, 2'b00, 1'b1);
        step(5);
        chk_all("s5_grn1", 2'd1, 2'b01, 2'b00, 2'b10, 1'b0);
        chk_lane("s5_grn1", 1'b1);
        step(1);
        chk_all("s5_yb", 2'd2, 2'b01, 2'b10, 2'b00, 1'b1);
        step(5);
        chk_all("s5_grn0", 2'd1, 2'b10, 2'b00, 2'b01, 1'b0);
        chk_lane("s5_grn0", 1'b0);

        // all switches off, then lane 0 requested again during yellow
        sw = 2'b00;
        step(7);
        chk_all("s6_pre", 2'd1, 2'b10, 2'b00, 2'b01, 1'b0);
        step(1);
        chk_all("s6_y", 2'd2, 2'b10, 2'b01, 2'b00, 1'b1);
        sw = 2'b01;
        step(2);
        chk_all("s6_y2", 2'd2, 2'b10, 2'b01, 2'b00, 1'b1);
        step(1);
        chk_all("s6_ar0", 2'd3, 2'b11, 2'b00, 2'b00, 1'b1);
        step(1);
        chk_all("s6_ar1", 2'd3, 2'b11, 2'b00, 2'b00, 1'b1);
        step(1);
        chk_all("s6_off", 2'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        chk_lane("s6_off", 1'b0);
        step(2);
        chk_all("s6_off2", 2'd0, 2'b00, 2'b00, 2'b00, 1'b0);
        step(1);
        chk_all("s6_ar2", 2'd3, 2'b11, 2'b00, 2'b00, 1'b1);
        step(2);
        chk_all("s6_grn", 2'd1, 2'b10, 2'b00, 2'b01, 1'b0);
        chk_lane("s6_grn", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
